// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared constants and state encodings for the FIFO-fed UART transmitter
// Contents: 3-bit state encodings, default bit period, 8N1 frame constants.
package fifo_uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_POP   = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_POP   = ST_POP,
        S_LOAD  = ST_LOAD,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP
    } state_e;

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// rtl/fifo_uart_tx_baud_cnt.sv - bit-period counter for the UART transmitter
// Ports: clk, rst (sync, active-high), clear (restart at 0), tick (count is at CLKS_PER_BIT-1).
module uart_baud_cnt
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - 8N1 UART transmitter that pops bytes from an upstream FIFO
// Ports: clk, rst (sync, active-high), enable (allow new frame), fifo_empty, fifo_data[7:0]
//        (valid the cycle after fifo_rd), fifo_rd (one pop per frame), tx (idle high), busy.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic       tx_q, tx_d;
    logic       rd_q, rd_d;
    logic       busy_q, busy_d;
    logic       tick;
    logic       clear;

    // Every state change restarts the bit period so each state lasts whole bit times.
    assign clear = (state_d != state_q);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE:  if (enable && !fifo_empty) state_d = S_POP;
            S_POP:   state_d = S_LOAD;
            S_LOAD: begin
                shift_d = fifo_data;
                state_d = S_START;
            end
            S_START: if (tick) state_d = S_DATA;
            S_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP:  if (tick) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        rd_d   = (state_d == S_POP);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
        end
    end

    assign tx      = tx_q;
    assign fifo_rd = rd_q;
    assign busy    = busy_q;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter CLKS_PER_BIT, default 868, SHALL set clk cycles per UART bit; legal range 2..65535.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 enable  input  1  permits starting a new frame; a frame already in progress is unaffected.
REQ-006 fifo_empty  input  1  empty flag of the upstream 8-deep byte FIFO.
REQ-007 fifo_data  input  8  FIFO read data; valid on the cycle after fifo_rd is high.
REQ-008 fifo_rd  output  1  FIFO pop strobe; at most one cycle per frame.
REQ-009 tx  output  1  serial line, 8N1, idle high.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, POP, LOAD, START, DATA and STOP.
REQ-012 IDLE->POP SHALL occur when enable=1 and fifo_empty=0; otherwise the FSM remains in IDLE.
REQ-013 fifo_rd SHALL be 1 only in POP and only for exactly one cycle; POP->LOAD is unconditional.
REQ-014 LOAD SHALL capture fifo_data into an 8-bit shift register and go to START; the byte is never re-read.
REQ-015 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles and then go to DATA.
REQ-016 DATA SHALL send 8 bits LSB first, each for exactly CLKS_PER_BIT cycles, using a 3-bit index that wraps from 7 to 0 on exit to STOP.
REQ-017 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles and then return to IDLE.
REQ-018 tx SHALL be 1 in IDLE, POP and LOAD, so the minimum inter-frame gap is CLKS_PER_BIT+3 cycles of high line.
REQ-019 tx SHALL be driven from a register, giving zero combinational glitches.
REQ-020 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, restart at 0 on every state entry, and flag terminal count at CLKS_PER_BIT-1.
REQ-021 If enable deasserts mid-frame, the frame SHALL complete and the FSM SHALL then hold in IDLE.
REQ-022 If fifo_empty rises during START, DATA or STOP, there SHALL be no effect on the current frame.
REQ-023 fifo_rd SHALL never assert while fifo_empty=1 is sampled in IDLE.

Reset
REQ-024 While rst=1 at a clk edge, the block SHALL load state=IDLE, tx=1, fifo_rd=0, busy=0, baud counter=0, bit index=0 and shift register=0.
REQ-025 A reset mid-frame SHALL abort the frame by forcing tx=1 on the next edge; the popped byte is discarded and is not re-read.
REQ-026 After reset release, the first fifo_rd SHALL occur no earlier than the second clk edge.

Structure
REQ-027 A shared package/header, fifo_uart_pkg, SHALL hold the state encodings (3-bit localparams), the default CLKS_PER_BIT and the frame constants (8 data bits, 1 stop bit).
REQ-028 The baud counter SHALL be a single sub-module, uart_baud_cnt, with inputs clk, rst and clear and output tick; all other logic stays in fifo_uart_tx.
REQ-029 The expected RTL size SHALL be 120-250 lines.

Verification (CLKS_PER_BIT=4, FIFO model with 1-cycle read latency)
REQ-030 Single byte: preload 0xA5, enable=1 -> one fifo_rd pulse, then tx reads 0 followed by 1,0,1,0,0,1,0,1 (LSB first) and 1, each 4 cycles; busy falls after 40 cycles of START..STOP.
REQ-031 Back-to-back: preload 0x00, 0xFF, 0x55 -> three frames with exactly 7 high cycles between the end of each data field and the next start bit; exactly 3 fifo_rd pulses.
REQ-032 Empty hold: fifo_empty=1 for 100 cycles with enable=1 -> fifo_rd=0, tx=1 and busy=0 throughout.
REQ-033 Reset mid-frame: assert rst for 1 cycle during data bit 3 of 0x3C -> tx=1 and busy=0 on the next edge; the next frame sends the following FIFO byte, not 0x3C.
REQ-034 Enable drop: deassert enable during START of 0x81 with 2 bytes queued -> 0x81 completes and no further fifo_rd occurs until enable=1.
REQ-035 Minimum divider: CLKS_PER_BIT=2, byte 0x01 -> every bit lasts 2 cycles and the frame totals 20 cycles.
